// File: rtl/dice_pkg.sv
// Shared constants for the dice display path.
//   SEG_0..SEG_9 : 7-segment patterns {g,f,e,d,c,b,a}, active high
//   SEG_DASH     : pattern shown for non-BCD values (10..15)
//   SEG_OFF      : all segments dark
//   SLOT_ONES / SLOT_TENS : values of the display slot bit
package dice_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic SLOT_ONES = 1'b0;
    localparam logic SLOT_TENS = 1'b1;

endpackage

// File: rtl/dice_display_mux_bcd_to_seg.sv
// bcd_to_seg: combinational BCD to 7-segment decoder.
//   bcd : 4-bit input digit
//   seg : 7-bit pattern {g,f,e,d,c,b,a}; values 10..15 decode to a dash
module bcd_to_seg
    import dice_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/dice_display_mux.sv
// dice_display_mux: 2-digit multiplexed common-cathode 7-segment driver.
//   clk        : system clock (32768 Hz)
//   rst_n      : asynchronous active-low reset
//   digit10    : tens BCD digit
//   digit1     : ones BCD digit
//   bright     : brightness 0..3 (on for 1/4..4/4 of each slot)
//   seg        : segments {g,f,e,d,c,b,a}, active high, registered
//   dig_en     : [0]=ones, [1]=tens, active high, registered, never both high
//   frame_sync : one-clock pulse when a new input snapshot is loaded
// Each slot lasts 2^REFRESH_DIV clocks; a frame is ones slot then tens slot.
// The first GUARD clocks of each slot are dark to avoid ghosting.
// Inputs are sampled only at the end of the tens slot so a frame never tears.
// Optional build macro LEADING_ZERO_BLANK_EN: blank the tens digit when it is 0.
module dice_display_mux
    import dice_pkg::*;
#(
    parameter int REFRESH_DIV = 6,
    parameter int GUARD       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit10,
    input  logic [3:0] digit1,
    input  logic [1:0] bright,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       frame_sync
);

    localparam logic [REFRESH_DIV:0] GUARD_W = (REFRESH_DIV+1)'(GUARD);
    localparam logic [REFRESH_DIV:0] ONE_W   = (REFRESH_DIV+1)'(1);

    logic [REFRESH_DIV-1:0] cnt;
    logic                   slot;
    logic [3:0]             tens_snap;
    logic [3:0]             ones_snap;
    logic [1:0]             bright_snap;

    logic                   wrap;
    logic                   boundary;
    logic [REFRESH_DIV:0]   cnt_ext;
    logic [REFRESH_DIV:0]   on_limit;
    logic                   lz_blank;
    logic                   on;
    logic [3:0]             digit_mux;
    logic [6:0]             seg_dec;

    assign wrap     = &cnt;
    assign boundary = wrap && (slot == SLOT_TENS);

    // One extra bit so that bright=3 gives a limit of exactly 2^REFRESH_DIV.
    assign cnt_ext  = {1'b0, cnt};
    assign on_limit = ({{(REFRESH_DIV-1){1'b0}}, bright_snap} + ONE_W) << (REFRESH_DIV-2);

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_blank = (slot == SLOT_TENS) && (tens_snap == 4'd0);
`else
    assign lz_blank = 1'b0;
`endif

    assign on        = (cnt_ext >= GUARD_W) && (cnt_ext < on_limit) && !lz_blank;
    assign digit_mux = (slot == SLOT_TENS) ? tens_snap : ones_snap;

    bcd_to_seg u_bcd_to_seg (
        .bcd (digit_mux),
        .seg (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            slot        <= SLOT_ONES;
            tens_snap   <= 4'd0;
            ones_snap   <= 4'd0;
            bright_snap <= 2'd0;
            seg         <= SEG_OFF;
            dig_en      <= 2'b00;
            frame_sync  <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (wrap) begin
                slot <= ~slot;
            end
            if (boundary) begin
                tens_snap   <= digit10;
                ones_snap   <= digit1;
                bright_snap <= bright;
            end
            frame_sync <= boundary;
            // Outputs reflect the (cnt, slot) state of this cycle, one clock late.
            if (on) begin
                dig_en <= (slot == SLOT_TENS) ? 2'b10 : 2'b01;
                seg    <= seg_dec;
            end else begin
                dig_en <= 2'b00;
                seg    <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_dice_display_mux.sv
// Testbench for dice_display_mux: directed scenarios plus random input
// changes, checked each cycle against a frame/slot arithmetic model.
module tb_dice_display_mux;

    localparam int RD    = 6;
    localparam int G     = 2;
    localparam int SLOT  = 1 << RD;
    localparam int FRAME = 2 * SLOT;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit10 = 4'd0;
    logic [3:0] digit1 = 4'd0;
    logic [1:0] bright = 2'd0;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       frame_sync;

    always #5 clk = ~clk;

    dice_display_mux #(.REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit10    (digit10),
        .digit1     (digit1),
        .bright     (bright),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_sync (frame_sync)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // p = position within the frame of the state the next edge acts on.
    int         p = 0;
    logic [3:0] m_tens = 4'd0, m_ones = 4'd0;
    logic [1:0] m_bright = 2'd0;
    logic [6:0] exp_seg = 7'd0;
    logic [1:0] exp_en = 2'd0;
    logic       exp_fs = 1'b0;

    task automatic predict();
        int  c, sl, lim;
        bit  on;
        logic [3:0] d;
        if (!rst_n) begin
            p = 0; m_tens = 0; m_ones = 0; m_bright = 0;
            exp_seg = 0; exp_en = 0; exp_fs = 0;
            return;
        end
        c   = p % SLOT;
        sl  = p / SLOT;
        lim = (int'(m_bright) + 1) * (SLOT / 4);
        on  = (c >= G) && (c < lim);
`ifdef LEADING_ZERO_BLANK_EN
        if (sl == 1 && m_tens == 0) on = 0;
`endif
        d       = (sl == 1) ? m_tens : m_ones;
        exp_seg = on ? SEG_TAB[d] : 7'd0;
        exp_en  = on ? ((sl == 1) ? 2'b10 : 2'b01) : 2'b00;
        exp_fs  = (p == FRAME - 1);
        if (p == FRAME - 1) begin
            m_tens = digit10; m_ones = digit1; m_bright = bright;
        end
        p = (p + 1) % FRAME;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        predict();
        @(negedge clk);
        check_val("seg", {1'b0, seg}, {1'b0, exp_seg});
        check_val("dig_en", {6'd0, dig_en}, {6'd0, exp_en});
        check_val("frame_sync", {7'd0, frame_sync}, {7'd0, exp_fs});
        check_val("dig_en_both", {7'd0, (dig_en == 2'b11)}, 8'd0);
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 40) == 0) begin
                digit10 = 4'($urandom_range(0, 15));
                digit1  = 4'($urandom_range(0, 15));
                bright  = 2'($urandom_range(0, 3));
            end
            tick();
        end
    endtask

    task automatic set_in(input logic [3:0] t, input logic [3:0] o, input logic [1:0] b);
        digit10 = t; digit1 = o; bright = b;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_in(4'd4, 4'd2, 2'd3);
        run(3, 0);                     // held in reset
        rst_n = 1'b1;
        run(2 * FRAME, 0);             // 42 at full brightness
        set_in(4'd4, 4'd2, 2'd0);
        run(2 * FRAME, 0);             // quarter brightness
        set_in(4'd4, 4'd2, 2'd1);
        run(2 * FRAME, 0);             // half brightness
        run(SLOT + 30, 0);             // into the tens slot
        set_in(4'd1, 4'd7, 2'd1);      // change mid tens slot
        run(SLOT - 30 + FRAME, 0);
        set_in(4'd3, 4'd12, 2'd2);     // invalid ones digit
        run(2 * FRAME, 0);
        set_in(4'd0, 4'd7, 2'd3);      // leading zero
        run(2 * FRAME, 0);
        run(8 * FRAME, 1);             // random changes
        set_in(4'd5, 4'd8, 2'd3);
        run(FRAME + 20, 0);            // mid ones slot, segments lit
        #2 rst_n = 1'b0;
        #1;
        check_val("async_seg", {1'b0, seg}, 8'd0);
        check_val("async_dig_en", {6'd0, dig_en}, 8'd0);
        check_val("async_fs", {7'd0, frame_sync}, 8'd0);
        run(2, 0);
        set_in(4'd9, 4'd9, 2'd3);
        rst_n = 1'b1;                  // first frame must show 00
        run(2 * FRAME, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
